wishbone_arbiter: RTL and testbench
===================================

# wishbone_arbiter

Multi-initiator front end for the Wishbone bus. It arbitrates `NUM_MASTERS` classic Wishbone initiators (CPU instruction port, data port, debug/DMA) onto one Wishbone target port. That target port normally feeds the address-decoding interconnect's master side. Arbitration is round-robin. Ownership is held for the full duration of the winner's `cyc`, so locked multi-transfer cycles are never split.

## Interface
- `NUM_MASTERS`, default 2: number of initiator ports (≥1).
- `clk`  in  1: bus clock, all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `masters[NUM_MASTERS]`  `wishbone_interface.slave`: initiator ports.
  - Signals: `cyc`, `stb`, `adr[31:0]`, `sel[3:0]`, `we`, `dat_mosi[31:0]` in; `dat_miso[31:0]`, `ack`, `err` out.
- `slave`  `wishbone_interface.master`: shared target port, same signal set, opposite direction.
- `grant`  out  `NUM_MASTERS`: one-hot current owner; all-zero when idle (debug/perf counters).

## Operation
- Reset values:
  - State IDLE, `grant`=0, round-robin pointer `ptr`=0.
  - All `slave.*` outputs are 0.
  - All `masters[i].ack/err/dat_miso` are 0.
- States: IDLE, BUSY. The state enum lives in the package.
- IDLE:
  - Request vector `req[i] = masters[i].cyc`.
  - If `req`≠0, pick the first set bit scanning from `ptr` upward modulo `NUM_MASTERS`, register it into `grant`, and go to BUSY.
  - If `req`=0, stay in IDLE.
- BUSY, owner `g`:
  - `slave.cyc = masters[g].cyc`; `slave.stb = masters[g].stb`.
  - `adr/sel/we/dat_mosi` are muxed from `g`.
  - `masters[g].ack/err/dat_miso` come from the slave.
  - Every other master sees `ack=err=0` and `dat_miso=0`.
- Release:
  - `masters[g].cyc` sampled low in BUSY → IDLE, `grant`←0, `ptr`←(g+1) mod `NUM_MASTERS`.
  - `stb` of the owner is irrelevant to release; only `cyc` counts.
- IDLE forwarding: all `slave.*` outputs are 0. Requesting masters wait; they receive no ack/err.
- `slave.err` (including interconnect decode/timeout errors) is passed to the owner unmodified and does not end ownership.
- `NUM_MASTERS`=1: `ptr` is constant 0 and the same state machine is used. Pointer width is `max(1,$clog2(NUM_MASTERS))`.

## Timing
- Grant latency:
  - A `cyc` rising before edge k in IDLE is granted at edge k.
  - `slave.cyc/stb` are asserted in the cycle after edge k.
  - Minimum arbitration latency is 1 cycle.
- Data path: owner→slave and slave→owner are purely combinational. No added latency per transfer, and back-to-back acks within one `cyc` are passed every cycle.
- Owner dropping `cyc`: `slave.cyc` falls in the same cycle (combinational gating).
- Handover: at least one IDLE cycle with `slave.cyc`=0 between owners. At a release edge, no new grant is made at that same edge.
- Simultaneous requests: resolved purely by `ptr` position. Requests arriving while BUSY are held off until release.
- Asynchronous reset mid-transfer:
  - `slave.cyc/stb` and all acks drop immediately on `rst_n` low.
  - After `rst_n` rises, re-arbitration starts from `ptr`=0.
- No combinational path from `masters[i].cyc` to `grant`; `grant` is a register.

## Structure
- `wishbone_arbiter_pkg`: `arb_state_e` {IDLE, BUSY} and a `rr_pick` width helper.
- Sub-module `rr_priority_select` (combinational, parameterised by N):
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `pick[N]`, `valid`.
  - Implemented as a double-width rotate-and-find-first.
- Top level: state register, `grant`/`ptr` registers, forward and return muxes.

## Test plan
- Single request: master 1 alone raises `cyc/stb` (adr=0x1000_0004, we=1) with `ptr`=0 → `grant`=2'b10 one cycle later. The slave sees identical fields. Slave ack reaches only master 1 in the same cycle.
- Tie and rotation: masters 0 and 1 request continuously, each doing one transfer per `cyc`. Grant order is 0,1,0,1. There is exactly one idle cycle between owners.
- Locked cycle: master 0 holds `cyc` for 4 acks while master 1 requests. Master 1 is not granted until the cycle after master 0 drops `cyc`. Master 1 never sees ack/err meanwhile.
- Error passthrough: slave asserts `err` for the owner (e.g. unmapped adr 0xFFFF_0000). The owner gets `err`, the other master gets 0, and the grant is kept until `cyc` falls.
- Reset mid-transfer: pull `rst_n` low while BUSY with `stb` high → `slave.cyc`=0 and `grant`=0 asynchronously. After release with both masters requesting, master 0 is granted first.
- `NUM_MASTERS`=3 fairness: all three request continuously → grant sequence 0,1,2,0,1,2. No master waits more than 2 ownerships.

Source files
------------

// File: rtl/wishbone_arbiter_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
package wishbone_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Pointer width for an N-way round-robin pick; a single master still needs one bit.
  function automatic int rr_pick_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wishbone_arbiter_if.sv
// Classic Wishbone point-to-point signal bundle with initiator/target views.
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;
  logic        err;

  modport master (
    output cyc, stb, adr, sel, we, dat_mosi,
    input  dat_miso, ack, err
  );

  modport slave (
    input  cyc, stb, adr, sel, we, dat_mosi,
    output dat_miso, ack, err
  );
endinterface

// File: rtl/wishbone_arbiter_rr_priority_select.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_priority_select
  import wishbone_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = rr_pick_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_pick;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_pick;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_req  = {req, req} >> ptr;
    rot_req  = dbl_req[N-1:0];
    rot_pick = rot_req & (~rot_req + N'(1));
    dbl_pick = {rot_pick, rot_pick} << ptr;
    pick     = dbl_pick[2*N-1:N];
    valid    = |req;
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter of NUM_MASTERS classic Wishbone initiators onto one target;
// the winner keeps the bus until it drops cyc.
module wishbone_arbiter
  import wishbone_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wishbone_interface.slave       masters [NUM_MASTERS],
  wishbone_interface.master      slave,
  output logic [NUM_MASTERS-1:0] grant
);

  localparam int PW = rr_pick_width(NUM_MASTERS);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          owner;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] m_stb;
  logic [NUM_MASTERS-1:0] m_we;
  logic [31:0]            m_adr [NUM_MASTERS];
  logic [3:0]             m_sel [NUM_MASTERS];
  logic [31:0]            m_dat [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] pick;
  logic                   pick_valid;

  logic        fwd_cyc, fwd_stb, fwd_we;
  logic [31:0] fwd_adr, fwd_dat;
  logic [3:0]  fwd_sel;

  // Return path is gated by the registered grant, so non-owners see all zeros.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_port
    assign req[i]   = masters[i].cyc;
    assign m_stb[i] = masters[i].stb;
    assign m_we[i]  = masters[i].we;
    assign m_adr[i] = masters[i].adr;
    assign m_sel[i] = masters[i].sel;
    assign m_dat[i] = masters[i].dat_mosi;

    assign masters[i].ack      = grant_q[i] & slave.ack;
    assign masters[i].err      = grant_q[i] & slave.err;
    assign masters[i].dat_miso = grant_q[i] ? slave.dat_miso : 32'h0;
  end

  rr_priority_select #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) u_select (
    .req   (req),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fwd_cyc = 1'b0;
    fwd_stb = 1'b0;
    fwd_we  = 1'b0;
    fwd_adr = '0;
    fwd_sel = '0;
    fwd_dat = '0;
    owner   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        fwd_cyc = req[i];
        fwd_stb = m_stb[i];
        fwd_we  = m_we[i];
        fwd_adr = m_adr[i];
        fwd_sel = m_sel[i];
        fwd_dat = m_dat[i];
        owner   = PW'(i);
      end
    end
  end

  assign slave.cyc      = fwd_cyc;
  assign slave.stb      = fwd_stb;
  assign slave.we       = fwd_we;
  assign slave.adr      = fwd_adr;
  assign slave.sel      = fwd_sel;
  assign slave.dat_mosi = fwd_dat;

  // Release only samples the owner's cyc; a new grant waits for the next IDLE edge.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick;
        end
      end
      BUSY: begin
        if (!(|(grant_q & req))) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (owner == PW'(NUM_MASTERS - 1)) ? '0 : owner + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Random and directed stimulus for 2- and 3-master arbiters against an ownership model.
module tb_wishbone_arbiter;

  localparam int ND = 2;

  logic clk;
  logic rst_n;

  logic        t_cyc [ND][3];
  logic        t_stb [ND][3];
  logic        t_we  [ND][3];
  logic [31:0] t_adr [ND][3];
  logic [3:0]  t_sel [ND][3];
  logic [31:0] t_dat [ND][3];
  logic        s_ack [ND];
  logic        s_err [ND];
  logic [31:0] s_dat [ND];

  logic [2:0]  g_out [ND];
  logic        o_cyc [ND];
  logic        o_stb [ND];
  logic        o_we  [ND];
  logic [31:0] o_adr [ND];
  logic [3:0]  o_sel [ND];
  logic [31:0] o_dat [ND];
  logic        r_ack [ND][3];
  logic        r_err [ND][3];
  logic [31:0] r_dat [ND][3];

  logic [1:0] grant2;
  logic [2:0] grant3;

  wishbone_interface m2 [2] ();
  wishbone_interface s2 ();
  wishbone_interface m3 [3] ();
  wishbone_interface s3 ();

  for (genvar i = 0; i < 3; i++) begin : g_c2
    if (i < 2) begin : g_on
      assign m2[i].cyc      = t_cyc[0][i];
      assign m2[i].stb      = t_stb[0][i];
      assign m2[i].we       = t_we[0][i];
      assign m2[i].adr      = t_adr[0][i];
      assign m2[i].sel      = t_sel[0][i];
      assign m2[i].dat_mosi = t_dat[0][i];
      assign r_ack[0][i]    = m2[i].ack;
      assign r_err[0][i]    = m2[i].err;
      assign r_dat[0][i]    = m2[i].dat_miso;
    end else begin : g_off
      assign r_ack[0][i] = 1'b0;
      assign r_err[0][i] = 1'b0;
      assign r_dat[0][i] = 32'h0;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_c3
    assign m3[i].cyc      = t_cyc[1][i];
    assign m3[i].stb      = t_stb[1][i];
    assign m3[i].we       = t_we[1][i];
    assign m3[i].adr      = t_adr[1][i];
    assign m3[i].sel      = t_sel[1][i];
    assign m3[i].dat_mosi = t_dat[1][i];
    assign r_ack[1][i]    = m3[i].ack;
    assign r_err[1][i]    = m3[i].err;
    assign r_dat[1][i]    = m3[i].dat_miso;
  end

  assign s2.ack = s_ack[0];
  assign s2.err = s_err[0];
  assign s2.dat_miso = s_dat[0];
  assign s3.ack = s_ack[1];
  assign s3.err = s_err[1];
  assign s3.dat_miso = s_dat[1];

  assign g_out[0] = {1'b0, grant2};
  assign g_out[1] = grant3;
  assign o_cyc[0] = s2.cyc;
  assign o_stb[0] = s2.stb;
  assign o_we[0]  = s2.we;
  assign o_adr[0] = s2.adr;
  assign o_sel[0] = s2.sel;
  assign o_dat[0] = s2.dat_mosi;
  assign o_cyc[1] = s3.cyc;
  assign o_stb[1] = s3.stb;
  assign o_we[1]  = s3.we;
  assign o_adr[1] = s3.adr;
  assign o_sel[1] = s3.sel;
  assign o_dat[1] = s3.dat_mosi;

  wishbone_arbiter #(.NUM_MASTERS(2)) dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .masters (m2),
    .slave   (s2),
    .grant   (grant2)
  );

  wishbone_arbiter #(.NUM_MASTERS(3)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .masters (m3),
    .slave   (s3),
    .grant   (grant3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int nmast [ND];
  int own   [ND];
  int ptr_m [ND];

  logic [2:0] seen_grant [ND];
  logic       seen_ack   [ND][3];
  logic       seen_err   [ND][3];
  logic [2:0] prev_g     [ND];
  int         idle_run   [ND];
  int seq0[$], seq1[$], gap0[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [2:0] g);
    int r = -1;
    for (int k = 0; k < 3; k++) if (g[k]) r = k;
    return r;
  endfunction

  // Reference: one owner at a time, first requester from ptr upward, ptr moves past a releasing owner.
  task automatic model_edge(input int d);
    int n = nmast[d];
    if (!rst_n) begin
      own[d]   = -1;
      ptr_m[d] = 0;
    end else if (own[d] < 0) begin
      for (int k = 0; k < n; k++) begin
        int c = (ptr_m[d] + k) % n;
        if (own[d] < 0 && t_cyc[d][c]) own[d] = c;
      end
    end else if (!t_cyc[d][own[d]]) begin
      ptr_m[d] = (own[d] + 1) % n;
      own[d]   = -1;
    end
  endtask

  task automatic check_dut(input int d);
    int o = own[d];
    logic [2:0]  eg;
    logic        ec, es, ew;
    logic [31:0] ea, ed;
    logic [3:0]  esel;
    string p = $sformatf("n%0d_", nmast[d]);
    eg = (o < 0) ? 3'b000 : 3'(1 << o);
    if (o >= 0) begin
      ec = t_cyc[d][o]; es = t_stb[d][o]; ew = t_we[d][o];
      ea = t_adr[d][o]; ed = t_dat[d][o]; esel = t_sel[d][o];
    end else begin
      ec = 1'b0; es = 1'b0; ew = 1'b0; ea = '0; ed = '0; esel = '0;
    end
    check({p, "grant"}, 64'(g_out[d]), 64'(eg));
    check({p, "s_cyc"}, 64'(o_cyc[d]), 64'(ec));
    check({p, "s_stb"}, 64'(o_stb[d]), 64'(es));
    check({p, "s_we"},  64'(o_we[d]),  64'(ew));
    check({p, "s_adr"}, 64'(o_adr[d]), 64'(ea));
    check({p, "s_sel"}, 64'(o_sel[d]), 64'(esel));
    check({p, "s_dat"}, 64'(o_dat[d]), 64'(ed));
    for (int i = 0; i < nmast[d]; i++) begin
      check($sformatf("%sm%0d_ack", p, i), 64'(r_ack[d][i]), 64'((i == o) && s_ack[d]));
      check($sformatf("%sm%0d_err", p, i), 64'(r_err[d][i]), 64'((i == o) && s_err[d]));
      check($sformatf("%sm%0d_dat", p, i), 64'(r_dat[d][i]), 64'((i == o) ? s_dat[d] : 32'h0));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check_dut(d);
      seen_grant[d] = g_out[d];
      for (int i = 0; i < 3; i++) begin
        seen_ack[d][i] = r_ack[d][i];
        seen_err[d][i] = r_err[d][i];
      end
      if (g_out[d] != 3'b000 && g_out[d] != prev_g[d]) begin
        if (d == 0) begin
          if (seq0.size() > 0) gap0.push_back(idle_run[d]);
          seq0.push_back(onehot_idx(g_out[d]));
        end else begin
          seq1.push_back(onehot_idx(g_out[d]));
        end
        idle_run[d] = 0;
      end
      if (g_out[d] == 3'b000) idle_run[d]++;
      prev_g[d] = g_out[d];
    end
    @(posedge clk);
    for (int d = 0; d < ND; d++) model_edge(d);
    #1;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < 3; i++) begin
        t_cyc[d][i] = 1'b0; t_stb[d][i] = 1'b0; t_we[d][i] = 1'b0;
        t_adr[d][i] = '0;   t_sel[d][i] = '0;   t_dat[d][i] = '0;
      end
      s_ack[d] = 1'b0; s_err[d] = 1'b0; s_dat[d] = '0;
    end
  endtask

  // Each master does one acked transfer per cyc, then re-requests immediately.
  task automatic rr_inputs();
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < nmast[d]; i++) begin
        if (t_stb[d][i] && seen_ack[d][i]) begin
          t_cyc[d][i] = 1'b0; t_stb[d][i] = 1'b0;
        end else begin
          t_cyc[d][i] = 1'b1; t_stb[d][i] = 1'b1;
          t_adr[d][i] = $urandom; t_dat[d][i] = $urandom;
        end
      end
  endtask

  task automatic rand_inputs();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < nmast[d]; i++) begin
        if (t_cyc[d][i]) begin
          if ($urandom_range(0, 4) == 0) t_cyc[d][i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          t_cyc[d][i] = 1'b1;
        end
        t_stb[d][i] = t_cyc[d][i] & 1'($urandom);
        t_we[d][i]  = 1'($urandom);
        t_adr[d][i] = $urandom;
        t_sel[d][i] = 4'($urandom);
        t_dat[d][i] = $urandom;
      end
      s_ack[d] = 1'($urandom);
      s_err[d] = ($urandom_range(0, 9) == 0);
      s_dat[d] = $urandom;
    end
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_grant_d%0d", d), 64'(g_out[d]), 64'(0));
      check($sformatf("rst_cyc_d%0d", d), 64'(o_cyc[d]), 64'(0));
      check($sformatf("rst_stb_d%0d", d), 64'(o_stb[d]), 64'(0));
      for (int i = 0; i < nmast[d]; i++)
        check($sformatf("rst_ack_d%0d_m%0d", d, i), 64'(r_ack[d][i]), 64'(0));
      own[d] = -1;
      ptr_m[d] = 0;
    end
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int k;
    nmast = '{2, 3};
    own   = '{-1, -1};
    ptr_m = '{0, 0};
    for (int d = 0; d < ND; d++) begin
      prev_g[d] = '0; idle_run[d] = 0; seen_grant[d] = '0;
      for (int i = 0; i < 3; i++) begin seen_ack[d][i] = 1'b0; seen_err[d][i] = 1'b0; end
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_grant2", 64'(grant2), 64'(0));
    check("reset_grant3", 64'(grant3), 64'(0));
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Single request from master 1 with ptr at 0.
    t_cyc[0][1] = 1'b1; t_stb[0][1] = 1'b1; t_we[0][1] = 1'b1;
    t_adr[0][1] = 32'h1000_0004; t_sel[0][1] = 4'hF; t_dat[0][1] = 32'hCAFE_0001;
    s_ack[0] = 1'b1; s_dat[0] = 32'h1234_5678;
    cycle();
    check("single_pre_grant", 64'(seen_grant[0]), 64'(0));
    cycle();
    check("single_grant", 64'(seen_grant[0]), 64'(3'b010));
    check("single_ack_m1", 64'(seen_ack[0][1]), 64'(1));
    check("single_ack_m0", 64'(seen_ack[0][0]), 64'(0));
    t_cyc[0][1] = 1'b0; t_stb[0][1] = 1'b0;
    repeat (2) cycle();

    // Continuous requests: rotation on both instances.
    seq0.delete(); seq1.delete(); gap0.delete();
    s_ack[0] = 1'b1; s_ack[1] = 1'b1;
    repeat (22) begin rr_inputs(); cycle(); end
    check("tie_seq_len", 64'(seq0.size() >= 4), 64'(1));
    for (int j = 0; j < 4 && j < seq0.size(); j++)
      check($sformatf("tie_owner%0d", j), 64'(seq0[j]), 64'(j % 2));
    for (int j = 0; j < 3 && j < gap0.size(); j++)
      check($sformatf("tie_gap%0d", j), 64'(gap0[j]), 64'(1));
    check("fair3_seq_len", 64'(seq1.size() >= 6), 64'(1));
    for (int j = 0; j < 6 && j < seq1.size(); j++)
      check($sformatf("fair3_owner%0d", j), 64'(seq1[j]), 64'(j % 3));
    clear_inputs();
    repeat (3) cycle();

    // Locked cycle: master 0 keeps cyc for 4 acks while master 1 waits.
    t_cyc[0][0] = 1'b1; t_stb[0][0] = 1'b1; s_ack[0] = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (seen_grant[0] != 3'b001 && k < 10);
    check("locked_grant_m0", 64'(seen_grant[0]), 64'(3'b001));
    t_cyc[0][1] = 1'b1; t_stb[0][1] = 1'b1;
    cnt = 0; k = 0;
    while (cnt < 4 && k < 20) begin
      cycle(); k++;
      if (seen_ack[0][0]) cnt++;
      check("locked_m1_ack", 64'(seen_ack[0][1]), 64'(0));
      check("locked_m1_err", 64'(seen_err[0][1]), 64'(0));
    end
    check("locked_ack_count", 64'(cnt), 64'(4));
    t_cyc[0][0] = 1'b0; t_stb[0][0] = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (seen_grant[0] != 3'b010 && k < 10);
    check("locked_handover_lat", 64'(k), 64'(3));
    clear_inputs();
    repeat (3) cycle();

    // Error passthrough keeps ownership.
    t_cyc[0][0] = 1'b1; t_stb[0][0] = 1'b1; t_adr[0][0] = 32'hFFFF_0000;
    s_err[0] = 1'b1;
    k = 0;
    do begin cycle(); k++; end while (seen_grant[0] != 3'b001 && k < 10);
    t_cyc[0][1] = 1'b1; t_stb[0][1] = 1'b1;
    repeat (3) begin
      cycle();
      check("err_owner", 64'(seen_err[0][0]), 64'(1));
      check("err_other", 64'(seen_err[0][1]), 64'(0));
      check("err_grant_kept", 64'(seen_grant[0]), 64'(3'b001));
    end
    t_cyc[0][0] = 1'b0; t_stb[0][0] = 1'b0;
    repeat (3) cycle();
    clear_inputs();
    repeat (3) cycle();

    // Reset mid-transfer, then both masters requesting.
    t_cyc[0][1] = 1'b1; t_stb[0][1] = 1'b1; s_ack[0] = 1'b1;
    repeat (2) cycle();
    t_cyc[0][0] = 1'b1; t_stb[0][0] = 1'b1;
    async_reset_pulse();
    repeat (2) cycle();
    check("rst_rearb_m0", 64'(seen_grant[0]), 64'(3'b001));
    clear_inputs();
    repeat (3) cycle();

    // Random traffic on both instances, with one asynchronous reset in the middle.
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      if (n == 1000) async_reset_pulse();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
